ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_WIDTH, default 31, giving the RAM address width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the RAM data width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 if_req  input  1  instruction-fetch read request; held with if_addr until granted.
REQ-006 if_addr  input  RAM_WIDTH  fetch address.
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch read data valid.
REQ-009 if_rdata  output  DATA_WIDTH  fetch read data.
REQ-010 ls_req  input  1  load/store request; held with ls_we, ls_addr and ls_wdata until granted.
REQ-011 ls_we  input  1  1 = store, 0 = load.
REQ-012 ls_addr  input  RAM_WIDTH  load/store address.
REQ-013 ls_wdata  input  DATA_WIDTH  store data.
REQ-014 ls_gnt  output  1  load/store request accepted this cycle.
REQ-015 ls_rvalid  output  1  load data valid (never asserted for stores).
REQ-016 ls_rdata  output  DATA_WIDTH  load data.
REQ-017 ram_address  output  RAM_WIDTH  RAM address.
REQ-018 ram_we  output  1  RAM write enable.
REQ-019 ram_data  inout  DATA_WIDTH  RAM data bus; driven with ls_wdata when ram_we=1, high-Z otherwise.

Function
REQ-020 At most one of if_gnt and ls_gnt SHALL be 1 in any cycle; a grant is combinational from the current requests and the arbitration state.
REQ-021 A sole requester SHALL be granted in the cycle it requests, giving one access per cycle with no idle cycle between back-to-back grants.
REQ-022 When granted, ram_address SHALL equal the winner's address; ram_we = ls_gnt & ls_we.
REQ-023 With no grant, ram_address SHALL hold its last driven value and ram_we SHALL be 0.
REQ-024 For a granted read in cycle N, the RAM data SHALL be registered at the end of cycle N and presented on the winner's rdata with rvalid=1 for exactly cycle N+1 (latency 1).
REQ-025 A granted store in cycle N SHALL write the RAM at the end of cycle N and SHALL produce no rvalid.
REQ-026 if_rdata and ls_rdata SHALL hold their last value while rvalid=0.
REQ-027 A registered arbitration state SHALL record the last winner: LAST_IF or LAST_LS; it updates only on a grant.
REQ-028 On a conflict (if_req=1, ls_req=1), the winner SHALL be chosen per REQ-033/REQ-034; the loser receives no grant and retries next cycle.
REQ-029 A request arriving in the same cycle as an rvalid for the same port SHALL be granted normally (responses and grants are independent pipelines).

Reset
REQ-030 While rst=1 at a rising edge: if_rvalid=0, ls_rvalid=0, if_rdata=0, ls_rdata=0, ram_address=0, arbitration state=LAST_LS.
REQ-031 While rst=1, if_gnt, ls_gnt and ram_we SHALL be 0 and ram_data SHALL be high-Z, regardless of requests.
REQ-032 A read granted in the cycle before reset asserts SHALL NOT produce rvalid after reset deasserts.

Configuration
REQ-033 With macro RAM_ARB_RR_EN defined, conflicts SHALL be resolved round-robin: the requester that is not the last winner wins (after reset the fetch port wins first).
REQ-034 Without RAM_ARB_RR_EN, conflicts SHALL be resolved with fixed priority, load/store over fetch; the arbitration state is still maintained but not used.

Verification
REQ-035 Reset, then if_req=1, if_addr=5, RAM[5]=0xDEADBEEF -> if_gnt=1 in the same cycle; if_rvalid=1 and if_rdata=0xDEADBEEF in the next cycle only.
REQ-036 ls_req=1, ls_we=1, ls_addr=9, ls_wdata=0x12345678, then a load from 9 -> ram_we=1 for one cycle; load returns 0x12345678; ls_rvalid never 1 for the store.
REQ-037 Both ports request continuously for 6 cycles with RR_EN -> grants IF, LS, IF, LS, IF, LS; without it -> LS for all 6 and if_gnt=0 throughout.
REQ-038 rst pulsed in the cycle after a fetch grant -> if_rvalid stays 0, outputs match REQ-030/REQ-031, and ram_data is high-Z.
REQ-039 Fetch reads 100 addresses back-to-back with no ls_req -> 100 consecutive grants and 100 consecutive rvalids, data matching RAM contents.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-ported RAM between an instruction-fetch port
// and a load/store port. Grants are combinational and one access is issued
// per cycle; read data returns with a latency of one cycle on the winning port.
// Optional feature: define RAM_ARB_RR_EN to resolve conflicts round-robin
// instead of the default fixed priority (load/store over fetch).
module ram_arbiter #(
    parameter int RAM_WIDTH  = 31,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [RAM_WIDTH-1:0]  if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [RAM_WIDTH-1:0]  ls_addr,
    input  logic [DATA_WIDTH-1:0] ls_wdata,
    output logic                  ls_gnt,
    output logic                  ls_rvalid,
    output logic [DATA_WIDTH-1:0] ls_rdata,
    output logic [RAM_WIDTH-1:0]  ram_address,
    output logic                  ram_we,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

`ifdef RAM_ARB_RR_EN
    localparam logic RrEn = 1'b1;
`else
    localparam logic RrEn = 1'b0;
`endif

    typedef enum logic {
        LAST_IF = 1'b0,
        LAST_LS = 1'b1
    } arb_state_e;

    arb_state_e            state_q, state_d;
    logic [RAM_WIDTH-1:0]  addr_q, addr_d;
    logic                  if_vld_q, ls_vld_q;
    logic [DATA_WIDTH-1:0] cap_q;
    logic [DATA_WIDTH-1:0] if_hold_q, ls_hold_q;
    logic                  grant_if, grant_ls;
    logic                  rd_grant;

    // Last-winner register; starts as LAST_LS so round-robin favours fetch first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LAST_LS;
        end else begin
            state_q <= state_d;
        end
    end

    // Pick the winner from current requests and the last winner; record it.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        state_d  = state_q;
        if (!rst) begin
            if (if_req && ls_req) begin
                if (RrEn && (state_q == LAST_LS)) begin
                    grant_if = 1'b1;
                end else begin
                    grant_ls = 1'b1;
                end
            end else if (if_req) begin
                grant_if = 1'b1;
            end else if (ls_req) begin
                grant_ls = 1'b1;
            end
            if (grant_if) begin
                state_d = LAST_IF;
            end else if (grant_ls) begin
                state_d = LAST_LS;
            end
        end
    end

    // Steer the winner's address to the RAM, otherwise keep the last one driven.
    always_comb begin
        addr_d = addr_q;
        if (grant_if) begin
            addr_d = if_addr;
        end else if (grant_ls) begin
            addr_d = ls_addr;
        end
    end

    assign if_gnt      = grant_if;
    assign ls_gnt      = grant_ls;
    assign ram_address = addr_d;
    assign ram_we      = grant_ls & ls_we;
    assign ram_data    = ram_we ? ls_wdata : {DATA_WIDTH{1'bz}};
    assign rd_grant    = grant_if | (grant_ls & ~ls_we);

    // Remember the address last presented so idle cycles keep the bus stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Capture read data at the end of the granted cycle and flag its owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_vld_q <= 1'b0;
            ls_vld_q <= 1'b0;
            cap_q    <= '0;
        end else begin
            if_vld_q <= grant_if;
            ls_vld_q <= grant_ls & ~ls_we;
            if (rd_grant) begin
                cap_q <= ram_data;
            end
        end
    end

    // Reset masks a response still in flight so it never surfaces afterwards.
    assign if_rvalid = if_vld_q & ~rst;
    assign ls_rvalid = ls_vld_q & ~rst;
    assign if_rdata  = if_rvalid ? cap_q : if_hold_q;
    assign ls_rdata  = ls_rvalid ? cap_q : ls_hold_q;

    // Keep each port's last delivered word visible between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_hold_q <= '0;
            ls_hold_q <= '0;
        end else begin
            if_hold_q <= if_rdata;
            ls_hold_q <= ls_rdata;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector table plus hand-written sequences for
// reset, conflict arbitration and back-to-back fetch streaming.
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        ifReq;
    logic [30:0] ifAddr;
    logic        ifGnt;
    logic        ifRvalid;
    logic [31:0] ifRdata;
    logic        lsReq;
    logic        lsWe;
    logic [30:0] lsAddr;
    logic [31:0] lsWdata;
    logic        lsGnt;
    logic        lsRvalid;
    logic [31:0] lsRdata;
    logic [30:0] ramAddress;
    logic        ramWe;
    wire  [31:0] ramData;

    logic [31:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.RAM_WIDTH(31), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (ifReq),
        .if_addr    (ifAddr),
        .if_gnt     (ifGnt),
        .if_rvalid  (ifRvalid),
        .if_rdata   (ifRdata),
        .ls_req     (lsReq),
        .ls_we      (lsWe),
        .ls_addr    (lsAddr),
        .ls_wdata   (lsWdata),
        .ls_gnt     (lsGnt),
        .ls_rvalid  (lsRvalid),
        .ls_rdata   (lsRdata),
        .ram_address(ramAddress),
        .ram_we     (ramWe),
        .ram_data   (ramData)
    );

    // The RAM model drives the bus asynchronously whenever the arbiter is not writing.
    assign ramData = ramWe ? 32'bz : mem[ramAddress[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: preload, then write on rising edges when enabled.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
        mem[5] = 32'hDEADBEEF;
        forever begin
            @(posedge clk);
            if (ramWe) mem[ramAddress[7:0]] <= ramData;
        end
    end

    typedef struct {
        logic        ifReq;
        logic [30:0] ifAddr;
        logic        lsReq;
        logic        lsWe;
        logic [30:0] lsAddr;
        logic [31:0] lsWdata;
        logic        eIfGnt;
        logic        eLsGnt;
        logic        eWe;
        logic [30:0] eAddr;
        logic        eIfV;
        logic        eLsV;
        logic [31:0] eIfRd;
        logic [31:0] eLsRd;
    } vec_t;

    vec_t vecs [13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic [30:0] ia, input logic lr,
                                 input logic lw, input logic [30:0] la, input logic [31:0] lwd);
        ifReq   = ir;
        ifAddr  = ia;
        lsReq   = lr;
        lsWe    = lw;
        lsAddr  = la;
        lsWdata = lwd;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 31'd0, 1'b0, 1'b0, 31'd0, 32'd0);
        nextCycle();
        nextCycle();
        rst = 1'b0;
    endtask

    logic expIf;
    logic prevIf;
    logic prevAny;
    logic [31:0] expWord;

    initial begin
        rst = 1'b1;
        applyStimulus(1'b1, 31'd44, 1'b1, 1'b1, 31'd45, 32'h55AA55AA);

        // Reset with both ports requesting a store: nothing may be granted or driven.
        nextCycle();
        @(negedge clk);
        checkOutput("rst_if_gnt", ifGnt, 0);
        checkOutput("rst_ls_gnt", lsGnt, 0);
        checkOutput("rst_ram_we", ramWe, 0);
        checkOutput("rst_if_rvalid", ifRvalid, 0);
        checkOutput("rst_ls_rvalid", lsRvalid, 0);
        checkOutput("rst_if_rdata", ifRdata, 0);
        checkOutput("rst_ls_rdata", lsRdata, 0);
        checkOutput("rst_ram_address", ramAddress, 0);
        checkOutput("rst_ram_data_released", ramData, 32'hC0DE0000);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 31'd0, 1'b0, 1'b0, 31'd0, 32'd0);

        //        ifR  ifA     lsR   lsWe  lsA    lsWd           gI  gL  we  addr   vI  vL  ifRd          lsRd
        vecs[0]  = '{1'b1, 31'd5,  1'b0, 1'b0, 31'd0, 32'h0,        1'b1, 1'b0, 1'b0, 31'd5,  1'b0, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 31'd0,  1'b0, 1'b0, 31'd0, 32'h0,        1'b0, 1'b0, 1'b0, 31'd5,  1'b1, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[2]  = '{1'b0, 31'd0,  1'b0, 1'b1, 31'd5, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 31'd5,  1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[3]  = '{1'b0, 31'd0,  1'b1, 1'b1, 31'd9, 32'h12345678, 1'b0, 1'b1, 1'b1, 31'd9,  1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[4]  = '{1'b0, 31'd0,  1'b1, 1'b0, 31'd9, 32'h0,        1'b0, 1'b1, 1'b0, 31'd9,  1'b0, 1'b0, 32'hDEADBEEF, 32'h0};
        vecs[5]  = '{1'b1, 31'd7,  1'b0, 1'b0, 31'd0, 32'h0,        1'b1, 1'b0, 1'b0, 31'd7,  1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678};
        vecs[6]  = '{1'b0, 31'd0,  1'b0, 1'b0, 31'd0, 32'h0,        1'b0, 1'b0, 1'b0, 31'd7,  1'b1, 1'b0, 32'hC0DE0007, 32'h12345678};
        vecs[7]  = '{1'b0, 31'd0,  1'b1, 1'b0, 31'd5, 32'h0,        1'b0, 1'b1, 1'b0, 31'd5,  1'b0, 1'b0, 32'hC0DE0007, 32'h12345678};
        vecs[8]  = '{1'b0, 31'd0,  1'b1, 1'b0, 31'd3, 32'h0,        1'b0, 1'b1, 1'b0, 31'd3,  1'b0, 1'b1, 32'hC0DE0007, 32'hDEADBEEF};
        vecs[9]  = '{1'b1, 31'd9,  1'b0, 1'b0, 31'd0, 32'h0,        1'b1, 1'b0, 1'b0, 31'd9,  1'b0, 1'b1, 32'hC0DE0007, 32'hC0DE0003};
        vecs[10] = '{1'b1, 31'd10, 1'b0, 1'b0, 31'd0, 32'h0,        1'b1, 1'b0, 1'b0, 31'd10, 1'b1, 1'b0, 32'h12345678, 32'hC0DE0003};
        vecs[11] = '{1'b0, 31'd0,  1'b0, 1'b0, 31'd0, 32'h0,        1'b0, 1'b0, 1'b0, 31'd10, 1'b1, 1'b0, 32'hC0DE000A, 32'hC0DE0003};
        vecs[12] = '{1'b0, 31'd0,  1'b0, 1'b0, 31'd0, 32'h0,        1'b0, 1'b0, 1'b0, 31'd10, 1'b0, 1'b0, 32'hC0DE000A, 32'hC0DE0003};

        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].ifReq, vecs[v].ifAddr, vecs[v].lsReq,
                          vecs[v].lsWe, vecs[v].lsAddr, vecs[v].lsWdata);
            @(negedge clk);
            checkOutput($sformatf("v%0d_if_gnt", v), ifGnt, vecs[v].eIfGnt);
            checkOutput($sformatf("v%0d_ls_gnt", v), lsGnt, vecs[v].eLsGnt);
            checkOutput($sformatf("v%0d_ram_we", v), ramWe, vecs[v].eWe);
            checkOutput($sformatf("v%0d_ram_address", v), ramAddress, vecs[v].eAddr);
            checkOutput($sformatf("v%0d_if_rvalid", v), ifRvalid, vecs[v].eIfV);
            checkOutput($sformatf("v%0d_ls_rvalid", v), lsRvalid, vecs[v].eLsV);
            checkOutput($sformatf("v%0d_if_rdata", v), ifRdata, vecs[v].eIfRd);
            checkOutput($sformatf("v%0d_ls_rdata", v), lsRdata, vecs[v].eLsRd);
            if (vecs[v].eWe) checkOutput($sformatf("v%0d_ram_data", v), ramData, vecs[v].lsWdata);
            nextCycle();
        end

        // Six cycles of continuous conflict straight after reset.
        doReset();
        prevAny = 1'b0;
        prevIf  = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k < 6) applyStimulus(1'b1, 31'd20, 1'b1, 1'b0, 31'd21, 32'h0);
            else       applyStimulus(1'b0, 31'd0, 1'b0, 1'b0, 31'd0, 32'h0);
`ifdef RAM_ARB_RR_EN
            expIf = ((k % 2) == 0);
`else
            expIf = 1'b0;
`endif
            @(negedge clk);
            if (k < 6) begin
                checkOutput($sformatf("cf%0d_if_gnt", k), ifGnt, expIf);
                checkOutput($sformatf("cf%0d_ls_gnt", k), lsGnt, !expIf);
                checkOutput($sformatf("cf%0d_ram_address", k), ramAddress, expIf ? 31'd20 : 31'd21);
            end
            checkOutput($sformatf("cf%0d_if_rvalid", k), ifRvalid, prevAny && prevIf);
            checkOutput($sformatf("cf%0d_ls_rvalid", k), lsRvalid, prevAny && !prevIf);
            if (prevAny && prevIf)  checkOutput($sformatf("cf%0d_if_rdata", k), ifRdata, 32'hC0DE0014);
            if (prevAny && !prevIf) checkOutput($sformatf("cf%0d_ls_rdata", k), lsRdata, 32'hC0DE0015);
            prevAny = (k < 6);
            prevIf  = expIf;
            nextCycle();
        end

        // Reset pulsed the cycle after a fetch grant must swallow its response.
        doReset();
        applyStimulus(1'b1, 31'd30, 1'b0, 1'b0, 31'd0, 32'h0);
        @(negedge clk);
        checkOutput("rp_grant_if_gnt", ifGnt, 1);
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b1, 31'd31, 1'b1, 1'b1, 31'd32, 32'h77777777);
        @(negedge clk);
        checkOutput("rp_in_rst_if_rvalid", ifRvalid, 0);
        checkOutput("rp_in_rst_if_gnt", ifGnt, 0);
        checkOutput("rp_in_rst_ls_gnt", lsGnt, 0);
        checkOutput("rp_in_rst_ram_we", ramWe, 0);
        checkOutput("rp_in_rst_ram_data", ramData, 32'hC0DE001E);
        nextCycle();
        rst = 1'b0;
        applyStimulus(1'b0, 31'd0, 1'b0, 1'b0, 31'd0, 32'h0);
        @(negedge clk);
        checkOutput("rp_after_if_rvalid", ifRvalid, 0);
        checkOutput("rp_after_ls_rvalid", lsRvalid, 0);
        checkOutput("rp_after_if_rdata", ifRdata, 0);
        checkOutput("rp_after_ram_address", ramAddress, 0);
        nextCycle();
        applyStimulus(1'b1, 31'd40, 1'b1, 1'b0, 31'd41, 32'h0);
        @(negedge clk);
`ifdef RAM_ARB_RR_EN
        checkOutput("rp_first_conflict_if_gnt", ifGnt, 1);
`else
        checkOutput("rp_first_conflict_if_gnt", ifGnt, 0);
`endif
        nextCycle();

        // One hundred back-to-back fetches from an untouched region.
        doReset();
        for (int i = 0; i <= 100; i++) begin
            if (i < 100) applyStimulus(1'b1, 31'(100 + i), 1'b0, 1'b0, 31'd0, 32'h0);
            else         applyStimulus(1'b0, 31'd0, 1'b0, 1'b0, 31'd0, 32'h0);
            @(negedge clk);
            if (i < 100) begin
                checkOutput($sformatf("bb%0d_if_gnt", i), ifGnt, 1);
                checkOutput($sformatf("bb%0d_ram_address", i), ramAddress, 31'(100 + i));
            end
            checkOutput($sformatf("bb%0d_if_rvalid", i), ifRvalid, (i > 0));
            if (i > 0) begin
                expWord = 32'hC0DE0000 | (32'd99 + 32'(i));
                checkOutput($sformatf("bb%0d_if_rdata", i), ifRdata, expWord);
            end
            nextCycle();
        end
        @(negedge clk);
        checkOutput("bb_tail_if_rvalid", ifRvalid, 0);
        checkOutput("bb_tail_if_rdata_hold", ifRdata, 32'hC0DE00C7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
